data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 19 +
 rtl/data_mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e     : transaction FSM states
//   REQ_CPU/AUX : requester indices into req_i/we_i/gnt_o/done_o
//   RD_LAT_DEF  : default memory read latency in cycles
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int REQ_CPU    = 0;
  localparam int REQ_AUX    = 1;
  localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector (purely combinational).
//   req    : request vector, bit 0 = CPU, bit 1 = auxiliary master
//   last   : index of the requester granted most recently
//   winner : index of the selected requester (meaningless when req == 0)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = 1'(REQ_CPU);
    if (req == 2'b11) winner = ~last;       // contended: the other one goes
    else if (req[REQ_AUX]) winner = 1'(REQ_AUX);
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port data memory between the CPU (requester 0) and an
// auxiliary master (requester 1). One transaction at a time:
//   IDLE -> ISSUE (1 cycle write / RD_LAT cycles read) -> [CAPTURE] -> DONE -> IDLE
// Ports:
//   clock, reset_n              : rising-edge clock, async active-low reset
//   req_i, we_i                 : per-requester request / write flag
//   addr0_i/addr1_i             : per-requester address
//   wdata0_i/wdata1_i           : per-requester write data
//   gnt_o, done_o               : one-cycle grant / completion pulses
//   rdata_o                     : data of the last completed read
//   busy_o                      : FSM not in IDLE
//   address_D, d_ena, wr_dena,
//   data_in, q_D                : memory side (wr_dena: 0 = write, 1 = read)
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [WIDTH-1:0] addr0_i,
  input  logic [WIDTH-1:0] addr1_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic [WIDTH-1:0] wdata1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] address_D,
  output logic             d_ena,
  output logic             wr_dena,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_D
);

  // Counter holds RD_LAT-1 down to 0 while a read sits in ISSUE.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             arb_win;

  rr_arb2 u_arb (
    .req    (req_i),
    .last   (last_q),
    .winner (arb_win)
  );

  // State register (and latched transaction context)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;          // CPU wins the first contended round
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic. Operands are latched at grant so the requester's
  // inputs are ignored for the rest of the transaction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d        = ISSUE;
          win_d          = arb_win;
          last_d         = arb_win;
          we_d           = we_i[arb_win];
          addr_d         = arb_win ? addr1_i : addr0_i;
          wdata_d        = arb_win ? wdata1_i : wdata0_i;
          cnt_d          = we_i[arb_win] ? '0 : CW'(RD_LAT - 1);
          gnt_d[arb_win] = 1'b1;
        end
      end
      ISSUE: begin
        if (we_q)            state_d = DONE;
        else if (cnt_q == 0) state_d = CAPTURE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      CAPTURE: begin
        rdata_d = q_D;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory side is only live in ISSUE, idle values elsewhere.
  always_comb begin
    d_ena     = 1'b0;
    wr_dena   = 1'b1;
    address_D = '0;
    data_in   = '0;
    done_o    = '0;
    busy_o    = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        d_ena     = 1'b1;
        wr_dena   = ~we_q;
        address_D = addr_q;
        data_in   = wdata_q;
      end
      DONE:    done_o[win_q] = 1'b1;
      default: ;
    endcase
  end

  assign gnt_o   = gnt_q;
  assign rdata_o = rdata_q;

endmodule
